// File: rtl/m_bcd_pkg.sv
// ---------------------------------------------------------------------------
// m_bcd_pkg
// Shared definitions for the digit-serial BCD add/subtract unit: digit
// width, operation encoding, controller states and a digit validity helper.
// ---------------------------------------------------------------------------
package m_bcd_pkg;

   localparam int BCD_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      FIX
   } state_e;

   // A BCD digit is legal only in the range 0..9.
   function automatic logic is_valid_bcd(input logic [BCD_W-1:0] d);
      return (d <= BCD_W'(9));
   endfunction

endpackage

// File: rtl/m_bcd_digit_addsub.sv
// ---------------------------------------------------------------------------
// m_bcd_digit_addsub
// Combinational single-digit BCD adder/subtractor.
//   x, y   : BCD digit operands
//   cin    : incoming carry (add) or borrow (subtract)
//   sub    : 0 = x+y+cin, 1 = x-y-cin
//   digit  : resulting BCD digit
//   cout   : outgoing carry (add) or borrow (subtract)
// ---------------------------------------------------------------------------
module m_bcd_digit_addsub
   import m_bcd_pkg::*;
(
   input  logic [BCD_W-1:0] x,
   input  logic [BCD_W-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic [BCD_W-1:0] digit,
   output logic             cout
);

   // One guard bit: holds 0..19 for add, and the sign for subtract.
   logic [BCD_W:0] s;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      s     = '0;
      digit = '0;
      cout  = 1'b0;
      if (sub) begin
         s = {1'b0, x} - {1'b0, y} - {{BCD_W{1'b0}}, cin};
         if (s[BCD_W]) begin
            // Negative: wrap back into 0..9 and borrow from the next digit.
            digit = s[BCD_W-1:0] + BCD_W'(10);
            cout  = 1'b1;
         end else begin
            digit = s[BCD_W-1:0];
         end
      end else begin
         s = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};
         if (s >= (BCD_W+1)'(10)) begin
            digit = s[BCD_W-1:0] - BCD_W'(10);
            cout  = 1'b1;
         end else begin
            digit = s[BCD_W-1:0];
         end
      end
   end

endmodule

// File: rtl/m_bcd_serial_addsub.sv
// ---------------------------------------------------------------------------
// m_bcd_serial_addsub
// Digit-serial BCD add/subtract with sign/magnitude result, one digit/clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while busy=0
//   op         : 0 = a+b, 1 = a-b
//   a, b       : DIGITS-digit BCD operands, units digit in [3:0]
//   busy       : operation in progress
//   done       : one-cycle pulse when result/neg/err are updated
//   result     : BCD result; top digit is the add carry (0 for subtract)
//   neg        : subtract result negative, result holds the magnitude
//   err        : an operand digit was >9, result forced to 0
// ---------------------------------------------------------------------------
module m_bcd_serial_addsub
   import m_bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        op,
   input  logic [BCD_W*DIGITS-1:0]     a,
   input  logic [BCD_W*DIGITS-1:0]     b,
   output logic                        busy,
   output logic                        done,
   output logic [BCD_W*(DIGITS+1)-1:0] result,
   output logic                        neg,
   output logic                        err
);

   localparam int OPW   = BCD_W * DIGITS;
   localparam int RESW  = BCD_W * (DIGITS + 1);
   localparam int IDX_W = $clog2(DIGITS) + 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

   state_e            state_q,  state_d;
   logic [IDX_W-1:0]  idx_q,    idx_d;
   logic              c_q,      c_d;
   logic [OPW-1:0]    a_q,      a_d;
   logic [OPW-1:0]    b_q,      b_d;
   logic              op_q,     op_d;
   logic [OPW-1:0]    acc_q,    acc_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;
   logic [RESW-1:0]   result_q, result_d;
   logic              neg_q,    neg_d;
   logic              err_q,    err_d;

   logic              in_valid;
   logic [BCD_W-1:0]  x_sel, y_sel, digit, top_digit;
   logic              sub_sel, cout;

   // Validity of the operands being captured on this edge.
   always_comb begin
      in_valid = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!is_valid_bcd(a[i*BCD_W +: BCD_W]) || !is_valid_bcd(b[i*BCD_W +: BCD_W]))
            in_valid = 1'b0;
      end
   end

   // ADD walks the operands; FIX computes 0 - partial to turn a ten's
   // complement partial result into its magnitude.
   always_comb begin
      x_sel   = '0;
      y_sel   = acc_q[int'(idx_q)*BCD_W +: BCD_W];
      sub_sel = 1'b1;
      if (state_q == ADD) begin
         x_sel   = a_q[int'(idx_q)*BCD_W +: BCD_W];
         y_sel   = b_q[int'(idx_q)*BCD_W +: BCD_W];
         sub_sel = (op_q == OP_SUB);
      end
   end

   m_bcd_digit_addsub u_digit (
      .x     (x_sel),
      .y     (y_sel),
      .cin   (c_q),
      .sub   (sub_sel),
      .digit (digit),
      .cout  (cout)
   );

   assign top_digit = (op_q == OP_ADD) ? {{(BCD_W-1){1'b0}}, cout} : '0;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      c_d      = c_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      neg_d    = neg_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (busy_q) begin
               // Invalid operand captured last edge: complete with error.
               busy_d   = 1'b0;
               done_d   = 1'b1;
               err_d    = 1'b1;
               neg_d    = 1'b0;
               result_d = '0;
            end else if (start) begin
               a_d    = a;
               b_d    = b;
               op_d   = op;
               idx_d  = '0;
               c_d    = 1'b0;
               busy_d = 1'b1;
               if (in_valid)
                  state_d = ADD;
            end
         end

         ADD: begin
            acc_d[int'(idx_q)*BCD_W +: BCD_W] = digit;
            c_d   = cout;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) begin
               if (op_q == OP_SUB && cout) begin
                  // a < b: partial holds the ten's complement of the magnitude.
                  state_d = FIX;
                  idx_d   = '0;
                  c_d     = 1'b0;
               end else begin
                  state_d  = IDLE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  err_d    = 1'b0;
                  neg_d    = 1'b0;
                  result_d = {top_digit, acc_d};
               end
            end
         end

         FIX: begin
            acc_d[int'(idx_q)*BCD_W +: BCD_W] = digit;
            c_d   = cout;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) begin
               state_d  = IDLE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               err_d    = 1'b0;
               neg_d    = 1'b1;
               result_d = {{BCD_W{1'b0}}, acc_d};
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: operand/partial registers are reset as well; they are few and this keeps the datapath free of X.
         state_q  <= IDLE;
         idx_q    <= '0;
         c_q      <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_ADD;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         c_q      <= c_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign neg    = neg_q;
   assign err    = err_q;

endmodule

// File: tb/tb_m_bcd_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_m_bcd_serial_addsub
// Directed self-checking bench for m_bcd_serial_addsub with DIGITS=4.
// Each operation is launched right after the previous done, so the
// sequence also covers back-to-back acceptance.
// ---------------------------------------------------------------------------
module tb_m_bcd_serial_addsub;

   localparam int DIGITS = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic                 op;
   logic [4*DIGITS-1:0]  a, b;
   logic                 busy, done, neg, err;
   logic [4*DIGITS+3:0]  result;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;

   always #5 clk = ~clk;

   m_bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .neg    (neg),
      .err    (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one request from the current (post-edge) time, then waits for
   // done with a cycle budget. With disturb set, start is held high with
   // different operands for the whole busy window.
   task automatic run_op(input string tag, input logic o,
                         input logic [4*DIGITS-1:0] av, input logic [4*DIGITS-1:0] bv,
                         input int exp_lat, input logic [4*DIGITS+3:0] exp_res,
                         input logic exp_neg, input logic exp_err, input bit disturb);
      int lat;
      bit seen;
      op    = o;
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a     = ~av;
      b     = ~bv;
      check({tag, ".busy_after_accept"}, busy, 1);
      check({tag, ".done_after_accept"}, done, 0);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         if (disturb) begin
            start = 1'b1;
            op    = ~o;
            a     = 16'h9999;
            b     = 16'h9999;
         end
         @(posedge clk); #1;
         lat++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check({tag, ".done_seen"}, seen, 1);
      check({tag, ".latency"}, lat, exp_lat);
      check({tag, ".result"}, result, exp_res);
      check({tag, ".neg"}, neg, exp_neg);
      check({tag, ".err"}, err, exp_err);
      check({tag, ".busy_at_done"}, busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("reset.busy",   busy,   0);
      check("reset.done",   done,   0);
      check("reset.result", result, 0);
      check("reset.neg",    neg,    0);
      check("reset.err",    err,    0);
      @(posedge clk); #1;

      // Additions: plain, carry ripple into the top digit, maximum.
      run_op("add_1234_5678", 1'b0, 16'h1234, 16'h5678, 4, 20'h06912, 1'b0, 1'b0, 1'b0);
      run_op("add_9999_0001", 1'b0, 16'h9999, 16'h0001, 4, 20'h10000, 1'b0, 1'b0, 1'b0);
      run_op("add_9999_9999", 1'b0, 16'h9999, 16'h9999, 4, 20'h19998, 1'b0, 1'b0, 1'b0);

      // Subtractions: negative via FIX, equal operands, positive, negative.
      run_op("sub_0003_0005", 1'b1, 16'h0003, 16'h0005, 8, 20'h00002, 1'b1, 1'b0, 1'b0);
      run_op("sub_0500_0500", 1'b1, 16'h0500, 16'h0500, 4, 20'h00000, 1'b0, 1'b0, 1'b0);
      run_op("sub_5000_1234", 1'b1, 16'h5000, 16'h1234, 4, 20'h03766, 1'b0, 1'b0, 1'b0);
      run_op("sub_1234_5000", 1'b1, 16'h1234, 16'h5000, 8, 20'h03766, 1'b1, 1'b0, 1'b0);

      // Invalid digits force result 0 / neg 0; a following valid op clears err.
      run_op("err_12A4",      1'b0, 16'h12A4, 16'h0000, 1, 20'h00000, 1'b0, 1'b1, 1'b0);
      run_op("add_0042_0058", 1'b0, 16'h0042, 16'h0058, 4, 20'h00100, 1'b0, 1'b0, 1'b0);
      run_op("err_b_900F",    1'b1, 16'h0001, 16'h900F, 1, 20'h00000, 1'b0, 1'b1, 1'b0);

      // Start held high with other operands while busy must be ignored.
      run_op("busy_ignore",   1'b0, 16'h1234, 16'h5678, 4, 20'h06912, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of ADD aborts at once and issues no done.
      op    = 1'b0;
      a     = 16'h1111;
      b     = 16'h2222;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("midreset.busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midreset.busy",   busy,   0);
      check("midreset.done",   done,   0);
      check("midreset.result", result, 0);
      check("midreset.neg",    neg,    0);
      check("midreset.err",    err,    0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("midreset.no_done", done, 0);
      end
      run_op("add_0001_0001", 1'b0, 16'h0001, 16'h0001, 4, 20'h00002, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
